axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Shares the core's single AXI read address/data channel pair (AR/R) between the instruction-fetch requester and the data-memory requester.
- Sits between the I-side/D-side cache miss logic and the top-level AXI master ports.
- Issues one burst read at a time and steers returning beats to the requester that owns the transaction.
- Write channels (AW/W/B) are out of scope.

Parameters:
- ID_INST, 4'd0, arid value used for instruction reads.
- ID_DATA, 4'd1, arid value used for data reads.
- AR_CACHE, 4'b0000, constant driven on arcache.
- FAIR, 1, 1 = alternate grants when both request; 0 = data side always has priority.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  synchronous active-high reset.
- inst_req  in  1  instruction read request; held until inst_ack.
- inst_addr  in  32  burst start address.
- inst_len  in  8  AXI arlen (beats-1).
- inst_size  in  3  AXI arsize.
- inst_ack  out  1  one-cycle pulse: request accepted, fields may change.
- inst_rdata  out  32  returned beat.
- inst_rvalid  out  1  beat valid.
- inst_rlast  out  1  final beat.
- inst_err  out  1  with rvalid: rresp!=OKAY or beat-count mismatch on that beat.
- data_req, data_addr, data_len, data_size, data_ack, data_rdata, data_rvalid, data_rlast, data_err: same widths and meaning, data side.
- arid  out  4.
- araddr  out  32.
- arlen  out  8.
- arsize  out  3.
- arburst  out  2.
- arlock  out  2.
- arcache  out  4.
- arprot  out  3.
- arvalid  out  1.
- arready  in  1.
- rid  in  4.
- rdata  in  32.
- rresp  in  2.
- rlast  in  1.
- rvalid  in  1.
- rready  out  1.

Behaviour:
- Single clock aclk; synchronous active-high reset areset.
- Reset state:
  - FSM = IDLE; arvalid=0; rready=0.
  - All *_ack, *_rvalid, *_rlast, *_err = 0.
  - araddr/arlen/arsize = 0; arid = ID_INST.
  - Beat counter = 0; last_grant = DATA, so the first contended grant goes to INST when FAIR=1.
- Constant outputs: arburst=2'b01 (INCR), arlock=0, arcache=AR_CACHE, arprot=0.
- FSM states:
  - IDLE -> ADDR: when any req is high. The winner is latched into owner, its fields are registered onto AR, and its *_ack pulses in that same transition cycle.
    - Arbitration: single requester wins.
    - Both requesting: FAIR=1 grants the side opposite last_grant; FAIR=0 grants data.
  - ADDR: arvalid=1. All AR fields stay stable until arready. On arvalid&&arready -> DATA; arvalid drops the next cycle; beat counter cleared.
  - DATA: rready=1. Each rvalid&&rready beat is forwarded combinationally to the owner: rdata, rvalid, rlast.
    - Beat counter increments on each beat.
    - Beat is accepted only if rid==owner's ID; a mismatched rid beat is consumed and flagged via owner's *_err.
    - On beat with rlast=1 -> IDLE; last_grant <- owner.
- Latency: req high in IDLE -> ack in the same cycle -> arvalid one cycle later. Minimum req-to-first-beat = 2 cycles plus slave latency.
- One outstanding transaction only; no request is accepted in ADDR or DATA; requests stay pending.
- Error check: *_err=1 on a beat if any of:
  - rresp!=2'b00;
  - rlast=1 while counter!=len;
  - counter==len without rlast.
  In the last case the FSM stays in DATA until rlast arrives; no data is dropped.
- Non-owner *_rvalid is always 0.
- Simultaneous req rising with rlast completion: the new grant is evaluated only in IDLE, so there is one idle cycle between bursts.
- Reset mid-burst: state is discarded and returns to IDLE. No owner output is asserted after reset.
- Counter is 8 bits, compared against the latched len; len=255 must not wrap early.

Decomposition:
- Shared package uranus_axi_pkg:
  - AXI constants: BURST_INCR, RESP_OKAY, SIZE_WORD.
  - FSM state enum {IDLE, ADDR, DATA}.
  - Requester enum {REQ_INST, REQ_DATA}.
- One natural sub-module: rr_arbiter2, a two-input grant with last_grant memory and FAIR select.
- R-channel steering stays inline.

Test Plan:
- Single inst read: inst_req, addr 0xBFC00000, len 7, size 2 -> ack cycle 0; arvalid cycle 1 with arid=0, arlen=7, arburst=1; 8 beats routed to inst_rdata; inst_rlast on the 8th; data_rvalid never high.
- Contention FAIR=1: both req in IDLE after reset -> inst granted first. With both still requesting, next grant data, then inst. Alternation holds for 6 bursts.
- Contention FAIR=0: both req continuously -> data granted every burst; inst starves; assert.
- arready backpressure: arready low 5 cycles -> araddr/arlen/arid stable, arvalid held high; on arready -> DATA next cycle.
- Errors:
  - rresp=2'b10 on beat 3 -> data_err=1 on that beat only.
  - rlast on beat 2 of len 3 -> err and return to IDLE.
  - rid=1 during inst burst -> inst_err.
- Reset mid-burst: areset high during beat 4 of 8 -> next cycle arvalid=0, rready=0, all rvalid 0. A new req after reset is served normally.

Source files
------------

// File: rtl/uranus_axi_pkg.sv
// Shared AXI read-side definitions for the uranus core.
//   BURST_INCR / RESP_OKAY / SIZE_WORD : AXI encodings used on the AR/R channels.
//   arb_state_e : read arbiter FSM states (IDLE, ADDR, DATA).
//   requester_e : which requester owns the current read (instruction or data side).
package uranus_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_WORD  = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_INST = 1'b0,
    REQ_DATA = 1'b1
  } requester_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input grant selector with last-grant memory.
//   clk, rst      : clock, synchronous active-high reset (last grant -> REQ_DATA).
//   req_inst/data : pending requests.
//   upd_en/upd_who: record who was served when a burst completes.
//   gnt_valid/gnt : combinational grant for the current cycle.
// With FAIR=1 a contended grant goes to the side not served last; with FAIR=0
// the data side always wins a contended grant.
module rr_arbiter2
  import uranus_axi_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_inst,
  input  logic       req_data,
  input  logic       upd_en,
  input  requester_e upd_who,
  output logic       gnt_valid,
  output requester_e gnt
);

  requester_e last_q, last_d;

  always_comb begin
    last_d    = last_q;
    gnt_valid = req_inst | req_data;
    gnt       = REQ_DATA;
    if (upd_en) last_d = upd_who;
    if (req_inst && !req_data) begin
      gnt = REQ_INST;
    end else if (req_inst && req_data && FAIR && (last_q == REQ_DATA)) begin
      gnt = REQ_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= REQ_DATA;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI AR/R channel pair between the instruction-fetch and the
// data-memory miss logic. One burst is outstanding at a time; returning beats
// are steered combinationally to the owner of the transaction.
//   aclk, areset           : clock, synchronous active-high reset.
//   inst_* / data_*        : requester side (req/addr/len/size in, ack pulse,
//                            forwarded rdata/rvalid/rlast, per-beat err).
//   ar*                    : AXI read address channel (master side).
//   r*, rready             : AXI read data channel (master side).
//   dbg_state              : current FSM state (arb_state_e encoding).
// Handshakes: a transfer happens on a cycle where valid && ready; arvalid and
// all AR fields are held stable from grant until arready; req is held by the
// requester until its ack pulse, which fires in the IDLE cycle that grants it.
module axi_read_arbiter
  import uranus_axi_pkg::*;
#(
  parameter logic [3:0] ID_INST  = 4'd0,
  parameter logic [3:0] ID_DATA  = 4'd1,
  parameter logic [3:0] AR_CACHE = 4'b0000,
  parameter bit         FAIR     = 1'b1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [7:0]  inst_len,
  input  logic [2:0]  inst_size,
  output logic        inst_ack,
  output logic [31:0] inst_rdata,
  output logic        inst_rvalid,
  output logic        inst_rlast,
  output logic        inst_err,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [7:0]  data_len,
  input  logic [2:0]  data_size,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic        data_rvalid,
  output logic        data_rlast,
  output logic        data_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [1:0]  dbg_state
);

  arb_state_e  state_q, state_d;
  requester_e  owner_q, owner_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [2:0]  arsize_q, arsize_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [7:0]  cnt_q, cnt_d;
  // Set once the len-th beat arrived without rlast: every later beat of this
  // burst is an overrun and is flagged until rlast finally shows up.
  logic        over_q, over_d;

  logic        gnt_valid;
  requester_e  gnt;
  logic        grant_now;
  logic        beat;
  logic        beat_err;
  logic        burst_done;
  logic [3:0]  owner_id;

  rr_arbiter2 #(.FAIR(FAIR)) u_arb (
    .clk      (aclk),
    .rst      (areset),
    .req_inst (inst_req),
    .req_data (data_req),
    .upd_en   (burst_done),
    .upd_who  (owner_q),
    .gnt_valid(gnt_valid),
    .gnt      (gnt)
  );

  always_comb begin
    beat       = (state_q == DATA) && rvalid;
    burst_done = beat && rlast;
    grant_now  = (state_q == IDLE) && gnt_valid && !areset;
    owner_id   = (owner_q == REQ_INST) ? ID_INST : ID_DATA;
    beat_err   = (rresp != RESP_OKAY) || (rid != owner_id) || over_q ||
                 (rlast && (cnt_q != arlen_q)) || (!rlast && (cnt_q == arlen_q));

    state_d  = state_q;
    owner_d  = owner_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    arsize_d = arsize_q;
    cnt_d    = cnt_q;
    over_d   = over_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = ADDR;
          owner_d = gnt;
          if (gnt == REQ_INST) begin
            arid_d   = ID_INST;
            araddr_d = inst_addr;
            arlen_d  = inst_len;
            arsize_d = inst_size;
          end else begin
            arid_d   = ID_DATA;
            araddr_d = data_addr;
            arlen_d  = data_len;
            arsize_d = data_size;
          end
        end
      end
      ADDR: begin
        if (arready) begin
          state_d = DATA;
          cnt_d   = 8'd0;
          over_d  = 1'b0;
        end
      end
      DATA: begin
        if (rvalid) begin
          cnt_d = cnt_q + 8'd1;
          if (!rlast && (cnt_q == arlen_q)) over_d = 1'b1;
          if (rlast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    arvalid_d = (state_d == ADDR);
    rready_d  = (state_d == DATA);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      owner_q   <= REQ_INST;
      arid_q    <= ID_INST;
      araddr_q  <= 32'd0;
      arlen_q   <= 8'd0;
      arsize_q  <= 3'd0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      cnt_q     <= 8'd0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      cnt_q     <= cnt_d;
      over_q    <= over_d;
    end
  end

  assign inst_ack    = grant_now && (gnt == REQ_INST);
  assign data_ack    = grant_now && (gnt == REQ_DATA);

  assign inst_rdata  = rdata;
  assign inst_rvalid = beat && (owner_q == REQ_INST);
  assign inst_rlast  = inst_rvalid && rlast;
  assign inst_err    = inst_rvalid && beat_err;
  assign data_rdata  = rdata;
  assign data_rvalid = beat && (owner_q == REQ_DATA);
  assign data_rlast  = data_rvalid && rlast;
  assign data_err    = data_rvalid && beat_err;

  assign arid      = arid_q;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arsize    = arsize_q;
  assign arburst   = BURST_INCR;
  assign arlock    = 2'b00;
  assign arcache   = AR_CACHE;
  assign arprot    = 3'b000;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter. Two instances share all inputs: dut
// (FAIR=1) and dut_nf (FAIR=0). All bursts on both sides use equal lengths so
// the two instances run in lockstep and only their grant choices differ.
module tb_axi_read_arbiter;
  import uranus_axi_pkg::*;

  // clock / reset
  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic        inst_req, data_req;
  logic [31:0] inst_addr, data_addr;
  logic [7:0]  inst_len, data_len;
  logic [2:0]  inst_size, data_size;
  logic        arready, rlast, rvalid;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  logic        inst_ack, inst_rvalid, inst_rlast, inst_err;
  logic        data_ack, data_rvalid, data_rlast, data_err;
  logic [31:0] inst_rdata, data_rdata, araddr;
  logic [3:0]  arid, arcache;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock, dbg_state;
  logic        arvalid, rready;

  logic        nf_inst_ack, nf_inst_rvalid, nf_inst_rlast, nf_inst_err;
  logic        nf_data_ack, nf_data_rvalid, nf_data_rlast, nf_data_err;
  logic [31:0] nf_inst_rdata, nf_data_rdata, nf_araddr;
  logic [3:0]  nf_arid, nf_arcache;
  logic [7:0]  nf_arlen;
  logic [2:0]  nf_arsize, nf_arprot;
  logic [1:0]  nf_arburst, nf_arlock, nf_dbg_state;
  logic        nf_arvalid, nf_rready;

  axi_read_arbiter #(.FAIR(1'b1)) dut (
    .aclk(aclk), .areset(areset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_len(inst_len), .inst_size(inst_size),
    .inst_ack(inst_ack), .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid),
    .inst_rlast(inst_rlast), .inst_err(inst_err),
    .data_req(data_req), .data_addr(data_addr), .data_len(data_len), .data_size(data_size),
    .data_ack(data_ack), .data_rdata(data_rdata), .data_rvalid(data_rvalid),
    .data_rlast(data_rlast), .data_err(data_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .dbg_state(dbg_state)
  );

  axi_read_arbiter #(.FAIR(1'b0)) dut_nf (
    .aclk(aclk), .areset(areset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_len(inst_len), .inst_size(inst_size),
    .inst_ack(nf_inst_ack), .inst_rdata(nf_inst_rdata), .inst_rvalid(nf_inst_rvalid),
    .inst_rlast(nf_inst_rlast), .inst_err(nf_inst_err),
    .data_req(data_req), .data_addr(data_addr), .data_len(data_len), .data_size(data_size),
    .data_ack(nf_data_ack), .data_rdata(nf_data_rdata), .data_rvalid(nf_data_rvalid),
    .data_rlast(nf_data_rlast), .data_err(nf_data_err),
    .arid(nf_arid), .araddr(nf_araddr), .arlen(nf_arlen), .arsize(nf_arsize),
    .arburst(nf_arburst), .arlock(nf_arlock), .arcache(nf_arcache), .arprot(nf_arprot),
    .arvalid(nf_arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(nf_rready),
    .dbg_state(nf_dbg_state)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int beat_no  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // driver tasks: every task starts and ends 1 time unit after a rising edge
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1; inst_req = 1'b0; data_req = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; rid = 4'd0; rresp = 2'b00; rdata = 32'd0;
    repeat (2) tick();
    areset = 1'b0;
  endtask

  task automatic set_req(input logic side_inst, input logic [31:0] a, input logic [7:0] l);
    if (side_inst) begin
      inst_req = 1'b1; inst_addr = a; inst_len = l; inst_size = SIZE_WORD;
    end else begin
      data_req = 1'b1; data_addr = a; data_len = l; data_size = SIZE_WORD;
    end
  endtask

  // IDLE cycle: check the ack pulse on both instances, then the AR fields.
  task automatic grant(input logic exp_inst, input logic [31:0] exp_addr,
                       input logic [7:0] exp_len, input string tag);
    logic nf_inst;
    nf_inst = inst_req && !data_req;
    #1;
    check({tag, "_inst_ack"}, 32'(inst_ack), 32'(exp_inst));
    check({tag, "_data_ack"}, 32'(data_ack), 32'(!exp_inst));
    check({tag, "_nf_data_ack"}, 32'(nf_data_ack), 32'(!nf_inst));
    check({tag, "_nf_inst_ack"}, 32'(nf_inst_ack), 32'(nf_inst));
    tick();
    check({tag, "_arvalid"}, 32'(arvalid), 32'd1);
    check({tag, "_arid"}, 32'(arid), exp_inst ? 32'd0 : 32'd1);
    check({tag, "_nf_arid"}, 32'(nf_arid), nf_inst ? 32'd0 : 32'd1);
    check({tag, "_araddr"}, araddr, exp_addr);
    check({tag, "_arlen"}, 32'(arlen), 32'(exp_len));
    check({tag, "_arsize"}, 32'(arsize), 32'd2);
    check({tag, "_arburst"}, 32'(arburst), 32'd1);
    check({tag, "_ack_gone"}, 32'(inst_ack | data_ack), 32'd0);
  endtask

  // Hold arready low for 'stall' cycles (AR must stay stable), then accept.
  task automatic ar_accept(input int stall, input logic [31:0] exp_addr,
                           input logic [7:0] exp_len, input logic [3:0] exp_id, input string tag);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold_arvalid"}, 32'(arvalid), 32'd1);
      check({tag, "_hold_araddr"}, araddr, exp_addr);
      check({tag, "_hold_arlen"}, 32'(arlen), 32'(exp_len));
      check({tag, "_hold_arid"}, 32'(arid), 32'(exp_id));
      check({tag, "_hold_rready"}, 32'(rready), 32'd0);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check({tag, "_arvalid_drop"}, 32'(arvalid), 32'd0);
    check({tag, "_rready"}, 32'(rready), 32'd1);
  endtask

  // One R beat; the owner must see it with the hand-computed err/last flags.
  task automatic beat(input logic [3:0] id, input logic [1:0] resp, input logic last,
                      input logic own_inst, input logic exp_err, input string tag);
    logic [31:0] d;
    d = 32'hD000_0000 + 32'(beat_no);
    beat_no++;
    exp_q.push_back(d);
    rvalid = 1'b1; rid = id; rdata = d; rresp = resp; rlast = last;
    #1;
    check({tag, "_rvalid"}, 32'(own_inst ? inst_rvalid : data_rvalid), 32'd1);
    check({tag, "_rdata"}, own_inst ? inst_rdata : data_rdata, exp_q.pop_front());
    check({tag, "_rlast"}, 32'(own_inst ? inst_rlast : data_rlast), 32'(last));
    check({tag, "_err"}, 32'(own_inst ? inst_err : data_err), 32'(exp_err));
    check({tag, "_other_rvalid"}, 32'(own_inst ? data_rvalid : inst_rvalid), 32'd0);
    tick();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    check({tag, "_rready"}, 32'(rready), 32'd0);
    check({tag, "_arvalid"}, 32'(arvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ei;
    int   n_err;
    int   n_last;
    inst_addr = 32'd0; inst_len = 8'd0; inst_size = 3'd0;
    data_addr = 32'd0; data_len = 8'd0; data_size = 3'd0;
    do_reset();

    // reset state
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_acks", 32'({inst_ack, data_ack}), 32'd0);
    check("rst_rvalids", 32'({inst_rvalid, data_rvalid, inst_rlast, data_rlast}), 32'd0);
    check("rst_errs", 32'({inst_err, data_err}), 32'd0);
    check("rst_arid", 32'(arid), 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_arlen", 32'(arlen), 32'd0);
    check("rst_arsize", 32'(arsize), 32'd0);
    check("rst_arburst", 32'(arburst), 32'd1);
    check("rst_consts", 32'({arlock, arcache, arprot}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // contention: FAIR alternates starting with inst, FAIR=0 always data
    set_req(1'b1, 32'h0000_1000, 8'd1);
    set_req(1'b0, 32'h0000_2000, 8'd1);
    for (int b = 0; b < 6; b++) begin
      ei = (b % 2 == 0);
      grant(ei, ei ? 32'h0000_1000 : 32'h0000_2000, 8'd1, "fair");
      ar_accept(0, ei ? 32'h0000_1000 : 32'h0000_2000, 8'd1, ei ? 4'd0 : 4'd1, "fair");
      beat(ei ? 4'd0 : 4'd1, 2'b00, 1'b0, ei, 1'b0, "fair_b0");
      beat(ei ? 4'd0 : 4'd1, 2'b00, 1'b1, ei, 1'b0, "fair_b1");
      check("fair_idle_gap", 32'(dbg_state), 32'(IDLE));
    end
    inst_req = 1'b0; data_req = 1'b0;

    // single inst burst with arready held off for 5 cycles
    set_req(1'b1, 32'hBFC0_0000, 8'd7);
    grant(1'b1, 32'hBFC0_0000, 8'd7, "inst1");
    inst_req = 1'b0; inst_addr = 32'h1234_5678; inst_len = 8'd3;
    ar_accept(5, 32'hBFC0_0000, 8'd7, 4'd0, "bp");
    for (int i = 0; i < 8; i++) beat(4'd0, 2'b00, (i == 7), 1'b1, 1'b0, "inst1");
    check_idle("inst1_end");

    // SLVERR on the third beat of a data burst
    set_req(1'b0, 32'h8000_0000, 8'd3);
    grant(1'b0, 32'h8000_0000, 8'd3, "resp");
    data_req = 1'b0;
    ar_accept(0, 32'h8000_0000, 8'd3, 4'd1, "resp");
    for (int i = 0; i < 4; i++)
      beat(4'd1, (i == 2) ? 2'b10 : 2'b00, (i == 3), 1'b0, (i == 2), "resp");
    check_idle("resp_end");

    // rlast on beat 2 of a len-3 burst
    set_req(1'b1, 32'h0000_4000, 8'd3);
    grant(1'b1, 32'h0000_4000, 8'd3, "early");
    inst_req = 1'b0;
    ar_accept(0, 32'h0000_4000, 8'd3, 4'd0, "early");
    beat(4'd0, 2'b00, 1'b0, 1'b1, 1'b0, "early_b0");
    beat(4'd0, 2'b00, 1'b1, 1'b1, 1'b1, "early_b1");
    check_idle("early_end");

    // data-side rid during an inst burst
    set_req(1'b1, 32'h0000_5000, 8'd1);
    grant(1'b1, 32'h0000_5000, 8'd1, "rid");
    inst_req = 1'b0;
    ar_accept(0, 32'h0000_5000, 8'd1, 4'd0, "rid");
    beat(4'd1, 2'b00, 1'b0, 1'b1, 1'b1, "rid_b0");
    beat(4'd0, 2'b00, 1'b1, 1'b1, 1'b0, "rid_b1");
    check_idle("rid_end");

    // rlast missing on the len-th beat: stay in DATA, flag until rlast
    set_req(1'b0, 32'h0000_6000, 8'd1);
    grant(1'b0, 32'h0000_6000, 8'd1, "nolast");
    data_req = 1'b0;
    ar_accept(0, 32'h0000_6000, 8'd1, 4'd1, "nolast");
    beat(4'd1, 2'b00, 1'b0, 1'b0, 1'b0, "nolast_b0");
    beat(4'd1, 2'b00, 1'b0, 1'b0, 1'b1, "nolast_b1");
    check("nolast_still_data", 32'(rready), 32'd1);
    beat(4'd1, 2'b00, 1'b1, 1'b0, 1'b1, "nolast_b2");
    check_idle("nolast_end");

    // len=255: 256 clean beats, counter must not wrap early
    set_req(1'b1, 32'h0001_0000, 8'd255);
    grant(1'b1, 32'h0001_0000, 8'd255, "len255");
    inst_req = 1'b0;
    ar_accept(0, 32'h0001_0000, 8'd255, 4'd0, "len255");
    n_err = 0; n_last = 0;
    for (int i = 0; i < 256; i++) begin
      rvalid = 1'b1; rid = 4'd0; rresp = 2'b00; rdata = 32'(i); rlast = (i == 255);
      #1;
      if (inst_err) n_err++;
      if (inst_rlast) n_last++;
      if (!inst_rvalid) n_err++;
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    check("len255_errs", 32'(n_err), 32'd0);
    check("len255_lasts", 32'(n_last), 32'd1);
    check_idle("len255_end");

    // reset during beat 4 of 8
    set_req(1'b1, 32'h0000_7000, 8'd7);
    grant(1'b1, 32'h0000_7000, 8'd7, "mrst");
    inst_req = 1'b0;
    ar_accept(0, 32'h0000_7000, 8'd7, 4'd0, "mrst");
    for (int i = 0; i < 3; i++) beat(4'd0, 2'b00, 1'b0, 1'b1, 1'b0, "mrst");
    rvalid = 1'b1; rid = 4'd0; rdata = 32'hDEAD_BEEF; rlast = 1'b0;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check_idle("mrst_after");
    check("mrst_inst_rvalid", 32'(inst_rvalid), 32'd0);
    check("mrst_data_rvalid", 32'(data_rvalid), 32'd0);
    check("mrst_err", 32'({inst_err, data_err}), 32'd0);
    rvalid = 1'b0;
    set_req(1'b0, 32'h0000_8000, 8'd0);
    grant(1'b0, 32'h0000_8000, 8'd0, "post");
    data_req = 1'b0;
    ar_accept(0, 32'h0000_8000, 8'd0, 4'd1, "post");
    beat(4'd1, 2'b00, 1'b1, 1'b0, 1'b0, "post_b0");
    check_idle("post_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
